// File: rtl/even_counter.sv
// Free-running even-valued up-counter: 0, 2, 4, ... wrapping modulo 2^WIDTH.
// Only the upper WIDTH-1 bits are stored; the LSB is tied low.
module even_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] count
);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("even_counter: WIDTH must be >= 2");
      end
   endgenerate

   localparam logic [WIDTH-2:0] HALF_STEP = (WIDTH-1)'(1);

   logic [WIDTH-2:0] half_q;
   logic [WIDTH-2:0] half_d;

   // Stepping the half-count by one advances count by two and wraps naturally.
   always_comb begin
      half_d = half_q + HALF_STEP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         half_q <= {(WIDTH-1){1'b0}};
      end else begin
         half_q <= half_d;
      end
   end

   assign count = {half_q, 1'b0};

endmodule

// File: tb/tb_even_counter.sv
// Directed self-checking bench for even_counter (WIDTH=4) plus a per-edge invariant monitor.
module tb_even_counter;

   logic       clk;
   logic       reset;
   logic [3:0] count;

   int checks;
   int failures;

   even_counter #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Invariant monitor: every edge after the first reset, count is even and follows reset/+2.
   logic       armed = 1'b0;
   logic [3:0] prev_v;
   logic       rst_v;
   logic [3:0] exp_v;
   always @(posedge clk) begin
      prev_v = count;
      rst_v  = reset;
      #1;
      if (armed) begin
         exp_v = rst_v ? 4'd0 : 4'(prev_v + 4'd2);
         checks++;
         if (count !== exp_v) begin
            failures++;
            $display("FAIL invariant_step t=%0t count=%0d expected=%0d", $time, count, exp_v);
         end
         checks++;
         if (count[0] !== 1'b0) begin
            failures++;
            $display("FAIL invariant_even t=%0t count=%0d expected LSB 0", $time, count);
         end
      end
      if (rst_v) armed = 1'b1;
   end

   task automatic test_reset();
      #8;
      checks++;
      if (count !== 4'd0) begin
         failures++;
         $display("FAIL reset count=%0d expected=0", count);
      end
      #2;
      reset = 1'b0;
   endtask

   task automatic test_count_sequence();
      logic [3:0] exp_tbl [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
      for (int i = 0; i < 5; i++) begin
         #10;
         checks++;
         if (count !== exp_tbl[i]) begin
            failures++;
            $display("FAIL count_seq[%0d] count=%0d expected=%0d", i, count, exp_tbl[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_tbl [10] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10,
                                   4'd12, 4'd14, 4'd0, 4'd2, 4'd4};
      reset = 1'b1;
      #10;
      checks++;
      if (count !== 4'd0) begin
         failures++;
         $display("FAIL wrap_start count=%0d expected=0", count);
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #10;
         checks++;
         if (count !== exp_tbl[i]) begin
            failures++;
            $display("FAIL wrap[%0d] count=%0d expected=%0d", i, count, exp_tbl[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] exp_tbl [2] = '{4'd6, 4'd8};
      for (int i = 0; i < 2; i++) begin
         #10;
         checks++;
         if (count !== exp_tbl[i]) begin
            failures++;
            $display("FAIL mid_pre[%0d] count=%0d expected=%0d", i, count, exp_tbl[i]);
         end
      end
      reset = 1'b1;
      #10;
      checks++;
      if (count !== 4'd0) begin
         failures++;
         $display("FAIL mid_reset count=%0d expected=0", count);
      end
      reset = 1'b0;
      #10;
      checks++;
      if (count !== 4'd2) begin
         failures++;
         $display("FAIL mid_after count=%0d expected=2", count);
      end
   endtask

   task automatic test_held_reset();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #10;
         checks++;
         if (count !== 4'd0) begin
            failures++;
            $display("FAIL held_reset[%0d] count=%0d expected=0", i, count);
         end
      end
      reset = 1'b0;
      #10;
      checks++;
      if (count !== 4'd2) begin
         failures++;
         $display("FAIL held_release count=%0d expected=2", count);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      test_reset();
      test_count_sequence();
      test_wrap();
      test_mid_reset();
      test_held_reset();
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
